ex_stage: RTL

Execute stage of the 5-stage LoongArch32 pipeline. It sits between the decode stage and the memory stage.
- Upstream: latches the decoded bundle from decode (resolved src1/src2, 5-bit ALU op, memory-access controls, destination info) under a valid/allowin handshake.
- Function: computes the ALU result, with single-cycle multiply and a 32-iteration restoring divider.
- Downstream: issues the data-SRAM request and forwards the result bundle to the memory stage.

---
 rtl/ex_stage.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage of the LoongArch32 pipeline: ALU, single-cycle multiplier,
// 32-step restoring divider, data-SRAM request generation and the EX->MEM handshake.
module ex_stage #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [31:0] ds_src1,
  input  logic [31:0] ds_src2,
  input  logic [4:0]  ds_alu_op,
  input  logic [4:0]  ds_rd,
  input  logic        ds_ref_we,
  input  logic        ds_res_from_dram,
  input  logic        ds_dram_we,
  input  logic [1:0]  ds_rdram_num,
  input  logic        ds_rdram_sign,
  input  logic [1:0]  ds_wdram_num,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [4:0]  es_rd,
  output logic        es_ref_we,
  output logic        es_res_from_dram,
  output logic [1:0]  es_rdram_num,
  output logic        es_rdram_sign,
  output logic [31:0] es_alu_result,
  output logic        es_fwd_we,
  output logic [4:0]  es_fwd_rd,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  logic        es_valid_q;
  logic [31:0] pc_q, src1_q, src2_q;
  logic [4:0]  alu_op_q, rd_q;
  logic        ref_we_q, res_from_dram_q, dram_we_q, rdram_sign_q;
  logic [1:0]  rdram_num_q, wdram_num_q;

  div_state_e  div_state_q, div_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;

  logic        is_div, div_signed, es_ready_go, bundle_ld;
  logic [32:0] div_shift;
  logic [31:0] div_trial;
  logic        div_fits;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] mul_u;
  logic [31:0] mulh_s;
  logic signed [31:0] s1_s, s2_s;
  logic [31:0] alu_res;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;

  assign is_div      = (alu_op_q >= 5'd20) && (alu_op_q <= 5'd23);
  assign div_signed  = (alu_op_q == 5'd20) || (alu_op_q == 5'd22);
  assign es_ready_go = !is_div || (div_state_q == DIV_DONE);
  assign es_allowin  = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign bundle_ld   = ds_to_es_valid && es_allowin;

  // Decode -> execute bundle register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid_q <= 1'b0;
    end else if (es_allowin) begin
      es_valid_q <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q            <= '0;
      src1_q          <= '0;
      src2_q          <= '0;
      alu_op_q        <= '0;
      rd_q            <= '0;
      ref_we_q        <= 1'b0;
      res_from_dram_q <= 1'b0;
      dram_we_q       <= 1'b0;
      rdram_num_q     <= '0;
      rdram_sign_q    <= 1'b0;
      wdram_num_q     <= '0;
    end else if (bundle_ld) begin
      pc_q            <= ds_pc;
      src1_q          <= ds_src1;
      src2_q          <= ds_src2;
      alu_op_q        <= ds_alu_op;
      rd_q            <= ds_rd;
      ref_we_q        <= ds_ref_we;
      res_from_dram_q <= ds_res_from_dram;
      dram_we_q       <= ds_dram_we;
      rdram_num_q     <= ds_rdram_num;
      rdram_sign_q    <= ds_rdram_sign;
      wdram_num_q     <= ds_wdram_num;
    end
  end

  // Restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  assign div_shift = {rem_q, quo_q[31]};
  assign div_fits  = div_shift >= {1'b0, dsr_q};
  assign div_trial = div_shift[31:0] - dsr_q;

  always_comb begin
    div_state_d = div_state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (es_valid_q && is_div) begin
          div_state_d = DIV_BUSY;
          cnt_d       = '0;
          quo_d       = neg_if(src1_q, div_signed && src1_q[31]);
          dsr_d       = neg_if(src2_q, div_signed && src2_q[31]);
          rem_d       = '0;
          qneg_d      = div_signed && (src1_q[31] ^ src2_q[31]);
          rneg_d      = div_signed && src1_q[31];
        end
      end
      DIV_BUSY: begin
        rem_d = div_fits ? div_trial : div_shift[31:0];
        quo_d = {quo_q[30:0], div_fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
          div_state_d = DIV_DONE;
          cnt_d       = '0;
        end
      end
      DIV_DONE: begin
        if (es_valid_q && ms_allowin) begin
          div_state_d = DIV_IDLE;
        end
      end
      default: div_state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_state_q <= DIV_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
    end
  end

  assign quo_fix = neg_if(quo_q, qneg_q);
  assign rem_fix = neg_if(rem_q, rneg_q);

  // One unsigned multiplier; the signed high word is corrected from it.
  assign mul_u  = {32'd0, src1_q} * {32'd0, src2_q};
  assign mulh_s = mul_u[63:32] - (src1_q[31] ? src2_q : 32'd0)
                               - (src2_q[31] ? src1_q : 32'd0);
  assign s1_s = src1_q;
  assign s2_s = src2_q;

  always_comb begin
    alu_res = 32'd0;
    case (alu_op_q)
      5'd0:  alu_res = src1_q + src2_q;
      5'd1:  alu_res = src1_q - src2_q;
      5'd2:  alu_res = {31'd0, s1_s < s2_s};
      5'd3:  alu_res = {31'd0, src1_q < src2_q};
      5'd4:  alu_res = src1_q & src2_q;
      5'd5:  alu_res = src1_q | src2_q;
      5'd6:  alu_res = ~(src1_q | src2_q);
      5'd7:  alu_res = src1_q ^ src2_q;
      5'd8:  alu_res = src1_q << src2_q[4:0];
      5'd9:  alu_res = src1_q >> src2_q[4:0];
      5'd10: alu_res = s1_s >>> src2_q[4:0];
      5'd11, 5'd12, 5'd13, 5'd14: alu_res = pc_q + 32'd4;
      5'd15: alu_res = src2_q;
      5'd16: alu_res = pc_q + src2_q;
      5'd17: alu_res = mul_u[31:0];
      5'd18: alu_res = mulh_s;
      5'd19: alu_res = mul_u[63:32];
      5'd20, 5'd21: alu_res = quo_fix;
      5'd22, 5'd23: alu_res = rem_fix;
      default: alu_res = 32'd0;
    endcase
  end

  // Store lane selection from the low address bits
  always_comb begin
    st_we    = 4'b0000;
    st_wdata = src2_q;
    case (wdram_num_q)
      2'd0: st_we = 4'b1111;
      2'd1: begin
        st_we    = 4'b0001 << alu_res[1:0];
        st_wdata = {4{src2_q[7:0]}};
      end
      2'd2: begin
        st_we    = 4'b0011 << {alu_res[1], 1'b0};
        st_wdata = {2{src2_q[15:0]}};
      end
      default: st_we = 4'b0000;
    endcase
  end

  assign data_sram_en    = es_valid_q && es_ready_go && ms_allowin
                           && (res_from_dram_q || dram_we_q);
  assign data_sram_we    = (data_sram_en && dram_we_q) ? st_we : 4'b0000;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = st_wdata;

  assign es_alu_result    = alu_res;
  assign es_pc            = pc_q;
  assign es_rd            = rd_q;
  assign es_ref_we        = ref_we_q;
  assign es_res_from_dram = res_from_dram_q;
  assign es_rdram_num     = rdram_num_q;
  assign es_rdram_sign    = rdram_sign_q;
  assign es_fwd_we        = es_valid_q && ref_we_q;
  assign es_fwd_rd        = rd_q;

endmodule
